serial_subtractor: RTL
======================

# serial_subtractor

Parametrised multi-cycle subtractor computing `diff = a - b - bin` over `WIDTH` bits, processing `DIGIT` bits per clock through a registered borrow chain. It generalises the single-bit full subtractor into a wide datapath unit with borrow-in/borrow-out chaining, a signed-overflow flag and valid/ready handshakes on both sides. It sits between operand producers and result consumers wherever area is preferred over single-cycle latency.

## Interface
- `WIDTH`, 32: operand and result width. Must be a multiple of `DIGIT`.
- `DIGIT`, 4: bits processed per cycle. `DIGIT == WIDTH` is legal and gives one RUN cycle.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow in.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  `a - b - bin` modulo 2^WIDTH.
- `bout`  out  1  borrow out of the MSB; 1 when unsigned `a < b + bin`.
- `ovf`  out  1  two's-complement overflow.

## Operation
- Define `N = WIDTH/DIGIT`. FSM states: IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready = 1`.
  - On `in_valid & in_ready`, load the `a`/`b` shift registers, set the borrow register to `bin` and the digit counter to 0, then go to RUN.
- **RUN:** each cycle:
  - Subtract the low `DIGIT` bits of `a`/`b` together with the borrow register.
  - Shift the `DIGIT` result bits into `diff` from the MSB side.
  - Shift `a`/`b` right by `DIGIT`.
  - Update the borrow register and increment the counter.
  - After digit `N-1`, go to DONE.
- **DONE:**
  - `out_valid = 1`. `diff`, `bout` and `ovf` are stable.
  - On `out_ready`, go to IDLE.
  - `in_ready = 0`. Operands are not accepted in the same cycle as the output handshake.
- **Per-bit logic:**
  - Difference: `x = a ^ b ^ c`.
  - Borrow: `y = (~a & b) | (~a & c) | (b & c)`.
- **Flags:**
  - `bout` is the final borrow register value.
  - `ovf` is the borrow out of the MSB XOR the borrow into the MSB. The borrow into the MSB is captured during the last digit.
- `in_ready` is decoded from the state. `out_valid`, `diff`, `bout` and `ovf` are registered.
- Inputs `a`, `b` and `bin` are sampled only at acceptance. Changes during RUN or DONE are ignored.

## Timing
- Reset: state IDLE, `in_ready = 1` from the first cycle after reset. `out_valid`, `diff`, `bout`, `ovf`, counter and borrow register are all 0.
- Latency: with acceptance at edge E0, `out_valid` rises after edge E(N).
- Minimum initiation interval is N+2 cycles: one IDLE cycle, N RUN cycles, and at least one DONE cycle.
- Backpressure: while `out_ready = 0` in DONE, all outputs are held indefinitely.
- `in_valid` may be held high across a busy period. The operands are taken on the first IDLE cycle.
- Reset mid-RUN or in DONE aborts the operation:
  - Outputs take their reset values after that edge.
  - No `out_valid` pulse is produced.
  - The partial result is discarded.
- `rst` takes priority over any simultaneous handshake.

## Structure
- Shared package `sub_pkg`:
  - FSM state encoding constants `S_IDLE`, `S_RUN`, `S_DONE`.
  - Helper for counter width, `clog2(N)` with a minimum of 1.
- Sub-module `digit_subtractor`:
  - Combinational, parametrised by `DIGIT`.
  - Ripple of per-bit full-subtractor cells.
  - Ports: `a`, `b`, `bin`, `diff`, `bout`, plus `bmsb` (borrow into the top bit), which is used for `ovf`.
- Top level holds the FSM, counter, shift registers and result/flag registers. Target 150–250 lines.

## Test plan
All cases use WIDTH=8, DIGIT=4 (N=2) unless stated.
- a=0x35, b=0x12, bin=0 -> diff=0x23, bout=0, ovf=0. `out_valid` rises 2 edges after acceptance.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0. Also a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
- a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Hold `out_ready = 0` for 5 cycles in DONE -> `out_valid`, `diff` and flags are held and `in_ready = 0`. On release, IDLE follows and the next operands held on `in_valid` are accepted in that cycle.
- Assert `rst` after the first RUN cycle -> no `out_valid`, and `in_ready = 1` next cycle. A subsequent a=0x35, b=0x12 gives 0x23.
- Random sweep of 1000 operations with random `in_valid`/`out_ready` gaps for WIDTH=8/DIGIT=8 (N=1) and WIDTH=32/DIGIT=4 (N=8) -> every result matches the reference model `a - b - bin`, including `bout` and `ovf`.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared constants for the serial subtractor.
// Holds the FSM encoding and the counter width helper.
package sub_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit ripple subtractor.
// Also exposes the borrow into the top bit for overflow detection.
module digit_subtractor #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout,
  output logic             bmsb
);

  logic [DIGIT:0] c;

  assign c[0] = bin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign diff[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (~a[i] & b[i])
                   | (~a[i] & c[i])
                   | (b[i] & c[i]);
  end

  assign bout = c[DIGIT];
  assign bmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin, DIGIT bits per clock.
// Valid/ready on both sides; result and flags held in DONE.
import sub_pkg::*;

module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_nx;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] d_dig;
  logic             d_bout;
  logic             d_bmsb;
  logic             last;

  digit_subtractor #(
    .DIGIT(DIGIT)
  ) u_dig (
    .a   (a_sh[DIGIT-1:0]),
    .b   (b_sh[DIGIT-1:0]),
    .bin (brw),
    .diff(d_dig),
    .bout(d_bout),
    .bmsb(d_bmsb)
  );

  // Result digits enter from the MSB side, so after N
  // shifts the first digit has reached the bottom.
  if (DIGIT == WIDTH) begin : g_one
    assign diff_nx = d_dig;
  end else begin : g_many
    assign diff_nx = {d_dig, diff[WIDTH-1:DIGIT]};
  end

  assign last     = (cnt == CW'(N - 1));
  assign in_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      brw       <= 1'b0;
      cnt       <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        (state == S_RUN): begin
          diff <= diff_nx;
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          brw  <= d_bout;
          cnt  <= cnt + CW'(1);
          if (last) begin
            bout      <= d_bout;
            ovf       <= d_bout ^ d_bmsb;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        (state == S_DONE): begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
